gpio_in_ctrl: RTL and testbench
===============================

Name: gpio_in_ctrl

Overview:
- Input-direction GPIO peripheral: samples WIDTH external pins, synchronises and debounces them, and exposes the value as a CPU-readable register.
- Detects per-bit rising/falling edges into a sticky, write-1-to-clear status register and drives a level interrupt.
- Sits on the same simple we/re memory-mapped bus as the GPIO output register; it is the read-side counterpart for inbound pins.

Parameters:
- WIDTH, 32, number of GPIO input pins and register width (1..32).
- DEBOUNCE, 4, consecutive stable cycles required before a debounced bit changes; 0 or 1 means no debounce.
- CNT_W, 8, width of each per-bit debounce counter; DEBOUNCE must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of clk).
- we  input  1  register write strobe.
- re  input  1  register read strobe.
- addr  input  2  register select: 0 DATA (RO), 1 RISE_EN (RW), 2 FALL_EN (RW), 3 STATUS (R/W1C).
- data_in  input  32  write data; bits above WIDTH are ignored.
- data_out  output  32  registered read data; bits above WIDTH read 0.
- gpio_in  input  WIDTH  asynchronous external pins.
- irq  output  1  level interrupt, high while any STATUS bit is set.

Behaviour:
- Reset (reset==0 at a clk edge) clears sync1, sync2, the debounced value deb, prev_deb, all counters, RISE_EN, FALL_EN, STATUS and data_out to 0. irq is therefore 0.
- Reset mid-debounce discards the partial count. No edge is reported for pins already high when reset releases; deb follows them after the normal latency, and that 0->1 is a rising edge.
- Synchroniser: two flops per bit. sync2 lags gpio_in by 2 edges and is the only value the rest of the logic uses.
- Debounce, per bit, DEBOUNCE=N>=2:
  - If sync2!=deb, cnt increments.
  - When cnt==N-1 and the mismatch persists, deb<=sync2 and cnt<=0.
  - Any cycle with sync2==deb clears cnt.
  - Result: deb changes on the Nth consecutive mismatch cycle.
- DEBOUNCE 0 or 1: deb<=sync2 every cycle.
- Pin-to-deb latency: 2 + max(N,1) edges.
- Edge detect: prev_deb<=deb every cycle.
  - rise = deb & ~prev_deb & RISE_EN.
  - fall = ~deb & prev_deb & FALL_EN.
  - STATUS bit sets one edge after deb changes.
- STATUS update each edge: STATUS <= (STATUS & ~w1c_mask) | rise | fall.
  - w1c_mask = data_in when we && addr==3, else 0.
  - A set event and a W1C clear of the same bit in the same cycle: set wins.
- Changing RISE_EN/FALL_EN does not affect bits already set in STATUS.
- irq = |STATUS, combinational from the STATUS register; no extra latency.
- Writes:
  - addr 1 loads RISE_EN and addr 2 loads FALL_EN, both from data_in[WIDTH-1:0] on the edge where we==1.
  - Writes to addr 0 are ignored.
- Reads: data_out is registered.
  - If re==1 at edge k, data_out after k is the selected register's value before edge k, so a read concurrent with a write returns the old value.
  - If re==0, data_out<=0.
- Simultaneous we and re to STATUS: the read returns pre-clear STATUS; the clear applies the same edge.
- A pin glitch shorter than N cycles after sync never changes deb and never sets STATUS.

Test Plan:
- Reset: hold reset=0 3 cycles with gpio_in=32'hFFFF_FFFF -> data_out=0, irq=0. Release, wait 2+4 cycles, read addr0 -> 32'hFFFF_FFFF; STATUS=0 because RISE_EN=0.
- Rising edge: write RISE_EN=32'h0000_0001, toggle gpio_in[0] 0->1 at edge k -> deb[0]=1 after edge k+6, STATUS=32'h1 and irq=1 after edge k+7. Read addr3 -> 32'h1.
- W1C: with STATUS=32'h3, write addr3 data_in=32'h1 -> STATUS=32'h2, irq stays 1. Write 32'h2 -> STATUS=0, irq=0.
- Glitch rejection: pulse gpio_in[5] high for 3 cycles with FALL_EN=RISE_EN=32'h20 -> deb[5] stays 0, STATUS=0, irq=0. Pulse for 6 cycles -> STATUS bit 5 set.
- Set-vs-clear collision: time W1C write of bit 0 to the same edge as a new rising event on bit 0 -> STATUS[0]=1 after that edge.
- Read timing: re=1 with addr=1 after RISE_EN=32'hA5 -> data_out=32'hA5 the next cycle; re=0 the following cycle -> data_out=0. Write addr0 with 32'hFFFF -> DATA unchanged.

Source files
------------

// File: rtl/gpio_in_ctrl_if.sv
// Register bus for the GPIO input block.
//   we, re   : write / read strobes
//   addr     : register select (0 DATA, 1 RISE_EN, 2 FALL_EN, 3 STATUS)
//   data_in  : write data
//   data_out : registered read data
// The master modport drives requests; the slave modport returns read data.
interface gpio_in_ctrl_if;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output we, re, addr, data_in, input data_out);
  modport slave  (input we, re, addr, data_in, output data_out);
endinterface

// File: rtl/gpio_in_ctrl.sv
// GPIO input peripheral: synchronises and debounces WIDTH external pins,
// exposes the debounced value as a read-only register, and latches per-bit
// rising/falling edges into a sticky W1C STATUS register driving a level irq.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-low
//   bus     : register bus (slave side)
//   gpio_in : asynchronous external pins
//   irq     : high while any STATUS bit is set

// Per-pin synchroniser + debouncer.  prev_deb is the debounced value one
// cycle earlier, used by the top level for edge detection.
module gpio_in_bit #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic deb,
  output logic prev_deb
);
  localparam logic [CNT_W-1:0] LAST = (DEBOUNCE > 1) ? CNT_W'(DEBOUNCE - 1) : '0;

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      deb      <= 1'b0;
      prev_deb <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= pin;
      sync2    <= sync1;
      prev_deb <= deb;
      if (DEBOUNCE <= 1) begin
        deb <= sync2;
        cnt <= '0;
      end else if (sync2 != deb) begin
        // deb flips on the Nth consecutive mismatch cycle
        if (cnt == LAST) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module gpio_in_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  gpio_in_ctrl_if.slave    bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);
  logic [WIDTH-1:0] deb, prev_deb;
  logic [WIDTH-1:0] rise_en, fall_en, status;
  logic [WIDTH-1:0] rise, fall, w1c_mask, din;
  logic [31:0]      rd_mux, data_out;

  gpio_in_bit #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_bit [WIDTH-1:0] (
    .clk      (clk),
    .reset    (reset),
    .pin      (gpio_in),
    .deb      (deb),
    .prev_deb (prev_deb)
  );

  assign din      = bus.data_in[WIDTH-1:0];
  assign rise     = deb & ~prev_deb & rise_en;
  assign fall     = ~deb & prev_deb & fall_en;
  assign w1c_mask = (bus.we && bus.addr == 2'd3) ? din : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      2'd0: rd_mux = 32'(deb);
      2'd1: rd_mux = 32'(rise_en);
      2'd2: rd_mux = 32'(fall_en);
      2'd3: rd_mux = 32'(status);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      data_out <= '0;
    end else begin
      if (bus.we && bus.addr == 2'd1) rise_en <= din;
      if (bus.we && bus.addr == 2'd2) fall_en <= din;
      // new events are OR-ed in after the clear, so a same-cycle set wins
      status   <= (status & ~w1c_mask) | rise | fall;
      // rd_mux holds pre-edge values, so reads see state before any write
      data_out <= bus.re ? rd_mux : 32'd0;
    end
  end

  assign bus.data_out = data_out;
  assign irq          = |status;
endmodule

// File: tb/tb_gpio_in_ctrl.sv
module tb_gpio_in_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_in;
  logic        irq;
  int          errors = 0;
  int          checks = 0;

  gpio_in_ctrl_if bus();

  gpio_in_ctrl #(.WIDTH(32), .DEBOUNCE(4), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .gpio_in (gpio_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [9];

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic [1:0] addr,
                       input logic [31:0] din);
    bus.we      = we;
    bus.re      = re;
    bus.addr    = addr;
    bus.data_in = din;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one-cycle register access, bus returns to idle afterwards
  task automatic wr(input logic [1:0] addr, input logic [31:0] d);
    drive(1'b1, 1'b0, addr, d);
    cyc();
    drive(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    drive(1'b0, 1'b1, addr, 32'd0);
    cyc();
    chk(name, bus.data_out, exp);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  initial begin
    //              we    re    addr  din           exp_dout      irq
    tbl[0] = '{1'b1, 1'b0, 2'd1, 32'h0000_00A5, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 32'h0,         32'h0000_00A5, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h0,        1'b0};
    tbl[3] = '{1'b1, 1'b1, 2'd2, 32'h0000_005A, 32'h0,        1'b0};
    tbl[4] = '{1'b0, 1'b1, 2'd2, 32'h0,         32'h0000_005A, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 32'h0000_FFFF, 32'h0,        1'b0};
    tbl[6] = '{1'b0, 1'b1, 2'd0, 32'h0,         32'h0,        1'b0};
    tbl[7] = '{1'b1, 1'b1, 2'd1, 32'h0,         32'h0000_00A5, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 2'd2, 32'h0,         32'h0000_005A, 1'b0};

    drive(1'b0, 1'b0, 2'd0, 32'd0);
    gpio_in = 32'hFFFF_FFFF;
    reset   = 1'b0;
    cyc(3);
    chk("reset data_out", bus.data_out, 32'h0);
    chk("reset irq", {31'd0, irq}, 32'h0);

    // pins high across reset release: deb follows after 2+4 edges
    reset = 1'b1;
    cyc(5);
    rd_chk("data one edge early", 2'd0, 32'h0);
    rd_chk("data after settle", 2'd0, 32'hFFFF_FFFF);
    rd_chk("status after reset", 2'd3, 32'h0);
    chk("irq after reset", {31'd0, irq}, 32'h0);

    gpio_in = 32'h0;
    cyc(8);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].din);
      cyc();
      chk($sformatf("tbl[%0d] dout", i), bus.data_out, tbl[i].exp_dout);
      chk($sformatf("tbl[%0d] irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    cyc();
    chk("re=0 clears dout", bus.data_out, 32'h0);

    // rising edge on bit 0
    wr(2'd1, 32'h1);
    gpio_in = 32'h1;
    cyc(5);
    drive(1'b0, 1'b1, 2'd0, 32'd0);
    cyc();
    chk("deb0 before latency", bus.data_out, 32'h0);
    chk("irq before set", {31'd0, irq}, 32'h0);
    cyc();
    chk("deb0 at latency", bus.data_out, 32'h1);
    chk("irq on rise", {31'd0, irq}, 32'h1);
    rd_chk("status rise0", 2'd3, 32'h1);

    // W1C, with bit 1 also pending
    wr(2'd1, 32'h3);
    gpio_in = 32'h3;
    cyc(8);
    rd_chk("status 3", 2'd3, 32'h3);
    drive(1'b1, 1'b1, 2'd3, 32'h1);
    cyc();
    chk("w1c read pre-clear", bus.data_out, 32'h3);
    chk("irq after clr bit0", {31'd0, irq}, 32'h1);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    rd_chk("status 2", 2'd3, 32'h2);
    wr(2'd3, 32'h2);
    chk("irq after clr bit1", {31'd0, irq}, 32'h0);
    rd_chk("status cleared", 2'd3, 32'h0);

    // glitch rejection on bit 5
    wr(2'd1, 32'h20);
    wr(2'd2, 32'h20);
    gpio_in = 32'h23;
    cyc(3);
    gpio_in = 32'h3;
    cyc(10);
    chk("glitch3 irq", {31'd0, irq}, 32'h0);
    rd_chk("glitch3 status", 2'd3, 32'h0);
    rd_chk("glitch3 data", 2'd0, 32'h3);
    gpio_in = 32'h23;
    cyc(6);
    gpio_in = 32'h3;
    cyc(12);
    chk("pulse6 irq", {31'd0, irq}, 32'h1);
    rd_chk("pulse6 status", 2'd3, 32'h20);
    wr(2'd3, 32'h20);
    chk("pulse6 cleared", {31'd0, irq}, 32'h0);

    // set-vs-clear collision on bit 0
    gpio_in = 32'h2;
    cyc(8);
    wr(2'd1, 32'h1);
    gpio_in = 32'h3;
    cyc(6);
    chk("collide pre irq", {31'd0, irq}, 32'h0);
    drive(1'b1, 1'b0, 2'd3, 32'h1);
    cyc();
    chk("collide set wins irq", {31'd0, irq}, 32'h1);
    drive(1'b0, 1'b0, 2'd0, 32'd0);
    rd_chk("collide status", 2'd3, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
